ntt_core_param: RTL and testbench
=================================

Name: ntt_core_param

Overview:
- Parametrised successor of the in-place 256-point NTT engine.
- Generic transform size N, data width and modulus, with runtime mode select: forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande).
- Loads N coefficients over a valid/ready stream, transforms in place using one butterfly per cycle with an external twiddle ROM, and streams results out with full output backpressure.
- Sits between the polynomial buffer and the pointwise-multiply stage.

Parameters:
- N, 256, transform length; power of two, 4..1024.
- LOGN, 8, log2(N).
- DW, 23, coefficient/twiddle width.
- Q, 8380417, prime modulus; Q < 2^DW.
- NINV, 8347681, N^-1 mod Q; used only with INTT_SCALE_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = forward NTT, 1 = inverse NTT; sampled on the first accepted input word.
- input_ready  out  1  high in IDLE and LOAD.
- input_valid  in  1  input word present.
- input_data  in  DW  coefficient; values must be < Q.
- tf_addr  out  LOGN  twiddle ROM index (combinational ROM).
- tf_data  in  DW  zeta[tf_addr], Montgomery-free, < Q.
- output_valid  out  1  output word present.
- output_ready  in  1  sink accepts word.
- output_data  out  DW  result coefficient, < Q.
- busy  out  1  high from first accepted input until last output handshake.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - rst_n low: state=IDLE; input_ready=1, output_valid=0, output_data=0, busy=0, tf_addr=0; all counters cleared; memory contents undefined.
  - Reset asserted mid-operation aborts immediately; no partial output is emitted.
- States: IDLE, LOAD, CALC, OUTPUT.
- IDLE: on input_valid, store word at index 0, latch mode, go to LOAD with in_cnt=1.
- LOAD: each input_valid&input_ready stores at in_cnt++. Gaps in input_valid stall with no effect. After word N-1 is stored, go to CALC next cycle.
- CALC: one butterfly per cycle on (X=mem[j], Y=mem[j+len]).
  - Forward:
    - len starts N/2 and halves per stage; stage ends after len=1.
    - k starts at 1 and increments per block; tf_addr=k; T=tf_data.
    - A=(X + T*Y) mod Q, B=(X - T*Y) mod Q.
  - Inverse:
    - len starts at 1 and doubles per stage; stage ends after len=N/2.
    - k starts at N-1 and decrements per block; tf_addr=k; T=(tf_data==0)?0:Q-tf_data.
    - A=(X+Y) mod Q, B=(T*(X-Y)) mod Q.
  - Write-back: mem[j]<=A, mem[j+len]<=B in the same cycle.
  - Iteration: j++ within a block; at block end, start+=2*len and j=start. At stage end, start=0, j=0.
  - Arithmetic: product is 2*DW bits, reduced mod Q. Subtraction adds Q before reduction, so no negative intermediates.
  - CALC lasts exactly (N/2)*LOGN cycles, then go to OUTPUT.
- OUTPUT:
  - output_data=mem[out_cnt] registered, with output_valid=1.
  - Advance on output_valid&output_ready. With output_ready low, output_data and output_valid hold stable.
  - After the handshake of word N-1: output_valid=0, busy=0, return to IDLE on the next cycle.
  - input_ready=0 throughout CALC and OUTPUT.
- Mode changes outside the first accepted word are ignored.
- Latency (N=256, no stalls): 256 load + 1024 calc + 1 register = first output 1281 cycles after the first input handshake.

Optional Feature:
- INTT_SCALE_EN defined: in inverse mode each output word is (mem[out_cnt]*NINV) mod Q, computed in the output register stage with no extra latency. Forward mode is unaffected.
- INTT_SCALE_EN undefined: no scaling in either mode; inverse results equal N times the true inverse (mod Q).

Test Plan:
- Forward, input mem[0]=1, rest 0, no stalls -> 256 outputs all equal 1; first output_valid 1281 cycles after the first handshake.
- Forward on all-zero input -> 256 zeros. tf_addr sequence over stage 0 is 1, then stage 1 is 2,3, then stage 2 is 4..7, and so on.
- Inverse (scale enabled), input all 1 -> output[0]=1, rest 0. With scale disabled -> output[0]=256, rest 0.
- Round trip: random coefficients < Q, forward then inverse with INTT_SCALE_EN -> original sequence bit-exact. Also vs golden model for input 0..255.
- Backpressure: output_ready low for 3 cycles at word 10, and input_valid gaps of 2 cycles every 16 words -> output_data held at word 10 while stalled; result identical to the no-stall run.
- Reset: rst_n low for 1 cycle mid-CALC -> output_valid=0, input_ready=1, busy=0 immediately. A following full transform gives correct results.

Source files
------------

// File: rtl/ntt_core_param.sv
// In-place radix-2 NTT/INTT engine: stream load, one butterfly per cycle, stream out.
// Optional INTT_SCALE_EN: multiply inverse-mode outputs by N^-1 in the output register stage.
module ntt_core_param #(
  parameter int          N    = 256,
  parameter int          LOGN = 8,
  parameter int          DW   = 23,
  parameter int unsigned Q    = 8380417,
  parameter int unsigned NINV = 8347681
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  output logic            input_ready,
  input  logic            input_valid,
  input  logic [DW-1:0]   input_data,
  output logic [LOGN-1:0] tf_addr,
  input  logic [DW-1:0]   tf_data,
  output logic            output_valid,
  input  logic            output_ready,
  output logic [DW-1:0]   output_data,
  output logic            busy
);

  localparam int PW = 2*DW + 1;
  localparam logic [PW-1:0]   QW    = PW'(Q);
  localparam logic [PW-1:0]   NINVW = PW'(NINV);
  localparam logic [LOGN:0]   ONE   = (LOGN+1)'(1);
  localparam logic [LOGN:0]   HALF  = (LOGN+1)'(N/2);
  localparam logic [LOGN:0]   N_W   = (LOGN+1)'(N);
  localparam logic [LOGN-1:0] LAST  = LOGN'(N-1);
`ifdef INTT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUTPUT} state_t;
  state_t state, state_nx;

  logic            mode_q;
  logic [LOGN-1:0] in_cnt, k;
  logic [LOGN:0]   len, start, j, out_cnt;
  logic [DW-1:0]   mem [N];

  logic            in_hs, out_hs, blk_end, stg_end, last_bf;
  logic [LOGN-1:0] ja, jb;
  logic [PW-1:0]   x, y, tfw, tw, ty, dif, a_w, b_w;

  assign input_ready = (state == IDLE) || (state == LOAD);
  assign busy        = (state != IDLE);
  assign tf_addr     = (state == CALC) ? k : '0;
  assign in_hs       = input_valid & input_ready;
  assign out_hs      = output_valid & output_ready;

  assign blk_end = (j == start + len - ONE);
  assign stg_end = blk_end && (start + (len << 1) == N_W);
  assign last_bf = stg_end && (mode_q ? (len == HALF) : (len == ONE));

  // Butterfly datapath; inverse twiddle is the negated zeta.
  always_comb begin
    ja  = j[LOGN-1:0];
    jb  = ja + len[LOGN-1:0];
    x   = PW'(mem[ja]);
    y   = PW'(mem[jb]);
    tfw = PW'(tf_data);
    tw  = tfw;
    ty  = '0;
    dif = '0;
    a_w = '0;
    b_w = '0;
    if (mode_q) begin
      tw  = (tfw == '0) ? '0 : QW - tfw;
      a_w = (x + y) % QW;
      dif = (x + QW - y) % QW;
      b_w = (tw * dif) % QW;
    end else begin
      ty  = (tw * y) % QW;
      a_w = (x + ty) % QW;
      b_w = (x + QW - ty) % QW;
    end
  end

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] v, input logic inv);
    logic [PW-1:0] p;
    p = (PW'(v) * NINVW) % QW;
    return (SCALE && inv) ? DW'(p) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_hs) state_nx = LOAD;
      LOAD:    if (in_hs && in_cnt == LAST) state_nx = CALC;
      CALC:    if (last_bf) state_nx = OUTPUT;
      OUTPUT:  if (out_hs && out_cnt == N_W) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 1'b0;
      in_cnt       <= '0;
      k            <= '0;
      len          <= '0;
      start        <= '0;
      j            <= '0;
      out_cnt      <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
    end else begin
      case (state)
        IDLE: if (in_hs) begin
          mode_q <= mode;
          in_cnt <= LOGN'(1);
        end
        LOAD: if (in_hs) begin
          in_cnt <= in_cnt + LOGN'(1);
          if (in_cnt == LAST) begin
            j     <= '0;
            start <= '0;
            len   <= mode_q ? ONE : HALF;
            k     <= mode_q ? LAST : LOGN'(1);
          end
        end
        CALC: begin
          out_cnt <= '0;
          if (blk_end) begin
            k <= mode_q ? k - LOGN'(1) : k + LOGN'(1);
            if (stg_end) begin
              start <= '0;
              j     <= '0;
              len   <= mode_q ? (len << 1) : (len >> 1);
            end else begin
              start <= start + (len << 1);
              j     <= start + (len << 1);
            end
          end else begin
            j <= j + ONE;
          end
        end
        OUTPUT: begin
          // out_cnt always points one past the word held in output_data.
          if (!output_valid && out_cnt == '0) begin
            output_data  <= scale(mem[0], mode_q);
            output_valid <= 1'b1;
            out_cnt      <= ONE;
          end else if (out_hs) begin
            if (out_cnt == N_W) begin
              output_valid <= 1'b0;
              out_cnt      <= '0;
            end else begin
              output_data <= scale(mem[out_cnt[LOGN-1:0]], mode_q);
              out_cnt     <= out_cnt + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient store has no reset; its contents are rewritten by every load.
  always_ff @(posedge clk) begin
    if (in_hs) mem[in_cnt] <= input_data;
    if (state == CALC) begin
      mem[ja] <= DW'(a_w);
      mem[jb] <= DW'(b_w);
    end
  end

endmodule

// File: tb/tb_ntt_core_param.sv
// Directed bench for ntt_core_param at N=256, Dilithium modulus and bit-reversed zeta ROM.
module tb_ntt_core_param;
  localparam int NN = 256;
  localparam int DW = 23;
  localparam longint QQ = 8380417;

  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0;
  logic input_valid = 1'b0, output_ready = 1'b1;
  logic [DW-1:0] input_data = '0;
  logic input_ready, output_valid, busy;
  logic [7:0] tf_addr;
  logic [DW-1:0] tf_data, output_data;

  logic [DW-1:0] zeta_rom [NN];
  logic [DW-1:0] din [NN], dout [NN], ref_out [NN], orig [NN];
  logic [7:0]    tf_log [1024];
  longint        mdl [NN];
  int vecs = 0, errs = 0, cyc = 0, t0 = 0, lat = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign tf_data = zeta_rom[tf_addr];

  ntt_core_param dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .input_ready(input_ready), .input_valid(input_valid), .input_data(input_data),
    .tf_addr(tf_addr), .tf_data(tf_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .busy(busy)
  );

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  function automatic longint powmod(input longint b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % QQ;
    return r;
  endfunction

  function automatic int brv8(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= 1 << (7 - i);
    return r;
  endfunction

  // Textbook Cooley-Tukey reference on mdl[].
  function automatic void ntt_ref();
    int kk = 0;
    longint z, t;
    for (int ln = 128; ln > 0; ln >>= 1)
      for (int st = 0; st < NN; st += 2*ln) begin
        kk++;
        z = longint'(zeta_rom[kk]);
        for (int jj = st; jj < st + ln; jj++) begin
          t = (z * mdl[jj+ln]) % QQ;
          mdl[jj+ln] = (mdl[jj] - t + QQ) % QQ;
          mdl[jj]    = (mdl[jj] + t) % QQ;
        end
      end
  endfunction

  task automatic load_words(input logic m, input bit gaps);
    for (int i = 0; i < NN; i++) begin
      @(negedge clk);
      if (gaps && i > 0 && i % 16 == 0) begin
        input_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
      input_valid = 1'b1;
      input_data  = din[i];
      mode        = (i == 0) ? m : ~m;   // later mode changes must be ignored
      @(posedge clk);
      if (i == 0) begin #1; t0 = cyc; end
    end
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic calc_log();
    for (int c = 0; c < 1024; c++) begin
      tf_log[c] = tf_addr;
      @(negedge clk);
    end
  endtask

  task automatic unload(input int stall_at);
    logic [DW-1:0] hold;
    int to;
    output_ready = 1'b1;
    for (int w = 0; w < NN; w++) begin
      to = 0;
      while (!output_valid && to < 50) begin @(negedge clk); to++; end
      if (!output_valid) begin chk("out_timeout", 0, 1); return; end
      if (w == 0) lat = cyc - t0 + 1;   // handshake cycle counts as cycle 1
      if (w == stall_at) begin
        output_ready = 1'b0;
        hold = output_data;
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", output_data, hold);
          chk("stall_valid", output_valid, 1);
        end
        output_ready = 1'b1;
      end
      dout[w] = output_data;
      @(negedge clk);
    end
    chk("end_valid", output_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_ready", input_ready, 1);
  endtask

  task automatic xform(input logic m, input bit gaps, input int stall_at);
    load_words(m, gaps);
    calc_log();
    unload(stall_at);
  endtask

  initial begin
    for (int i = 0; i < NN; i++) zeta_rom[i] = DW'(powmod(1753, brv8(i)));
    repeat (3) @(negedge clk);
    chk("rst_ready", input_ready, 1);
    chk("rst_valid", output_valid, 0);
    chk("rst_data", output_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tfaddr", tf_addr, 0);
    rst_n = 1'b1;

    // Forward of a delta: every evaluation equals 1.
    for (int i = 0; i < NN; i++) din[i] = (i == 0) ? 23'd1 : 23'd0;
    xform(1'b0, 1'b0, -1);
    chk("latency", lat, 1281);
    for (int i = 0; i < NN; i++) chk("fwd_delta", dout[i], 1);

    // Forward of zeros, plus the twiddle index walk.
    for (int i = 0; i < NN; i++) din[i] = '0;
    xform(1'b0, 1'b0, -1);
    for (int i = 0; i < NN; i++) chk("fwd_zero", dout[i], 0);
    for (int c = 0; c < 1024; c++) begin
      int s, b;
      s = c / 128;
      b = (c % 128) / (128 >> s);
      chk("tf_addr", tf_log[c], (1 << s) + b);
    end

    // Inverse of all-ones is a (scaled) delta.
    for (int i = 0; i < NN; i++) din[i] = 23'd1;
    xform(1'b1, 1'b0, -1);
    for (int i = 0; i < NN; i++)
`ifdef INTT_SCALE_EN
      chk("inv_ones", dout[i], (i == 0) ? 1 : 0);
`else
      chk("inv_ones", dout[i], (i == 0) ? 256 : 0);
`endif

    // Ramp against the reference, then repeated with input gaps and an output stall.
    for (int i = 0; i < NN; i++) begin din[i] = DW'(i); mdl[i] = i; end
    ntt_ref();
    xform(1'b0, 1'b0, -1);
    for (int i = 0; i < NN; i++) begin
      chk("fwd_ramp", dout[i], 32'(mdl[i]));
      ref_out[i] = dout[i];
    end
    xform(1'b0, 1'b1, 10);
    for (int i = 0; i < NN; i++) chk("stall_run", dout[i], ref_out[i]);

    // Abort mid-CALC.
    load_words(1'b0, 1'b0);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", output_valid, 0);
    chk("abort_ready", input_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random round trip.
    for (int i = 0; i < NN; i++) begin
      orig[i] = DW'($urandom_range(0, 32'(QQ - 1)));
      din[i]  = orig[i];
      mdl[i]  = longint'(orig[i]);
    end
    ntt_ref();
    xform(1'b0, 1'b0, -1);
    for (int i = 0; i < NN; i++) begin
      chk("rt_fwd", dout[i], 32'(mdl[i]));
      din[i] = dout[i];
    end
    xform(1'b1, 1'b0, -1);
    for (int i = 0; i < NN; i++)
`ifdef INTT_SCALE_EN
      chk("rt_inv", dout[i], orig[i]);
`else
      chk("rt_inv", dout[i], 32'((longint'(orig[i]) * 256) % QQ));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
